// File: rtl/pwm_comparador_deadtime.sv
//------------------------------------------------------------------------------
// pwm_comparador_deadtime
//
// Purpose:
//   PWM compare stage that sits behind a free-running period counter. The
//   counter value is compared against a double-buffered duty register, and
//   the result drives a complementary high/low gate pair with a programmable
//   dead interval between them. A new duty value is held in a pending buffer
//   and only becomes active at the period wrap, so a period never changes its
//   duty part-way through.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_ena          shared enable with the period counter; low freezes this block
//   i_count        period counter value (0..MAX_VALUE, wraps to 0)
//   i_duty_in      new duty value
//   i_duty_wr      one-cycle write strobe for i_duty_in (honoured even if !i_ena)
//   i_dead_time    dead interval in clk cycles; 0 disables the dead interval
//   o_pwm_h        high-side gate, decoded from the state register
//   o_pwm_l        low-side gate, decoded from the state register
//   o_duty_active  duty currently used for comparison
//   o_pend         a written duty is waiting for the next wrap
//   o_period_start one-cycle pulse after the wrap edge
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module pwm_comparador_deadtime #(
   parameter int RESOLUTION_BITS = 8,
   parameter int DEAD_BITS       = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_ena,
   input  logic [RESOLUTION_BITS-1:0] i_count,
   input  logic [RESOLUTION_BITS-1:0] i_duty_in,
   input  logic                       i_duty_wr,
   input  logic [DEAD_BITS-1:0]       i_dead_time,
   output logic                       o_pwm_h,
   output logic                       o_pwm_l,
   output logic [RESOLUTION_BITS-1:0] o_duty_active,
   output logic                       o_pend,
   output logic                       o_period_start
);

   localparam logic [RESOLUTION_BITS-1:0] MAX_VALUE = '1;

   typedef enum logic [2:0] {
      S_OFF,
      S_LOW,
      S_DT_RISE,
      S_HIGH,
      S_DT_FALL
   } state_t;

   state_t                     r_state;
   state_t                     w_state_next;
   logic [DEAD_BITS-1:0]       r_dcnt;
   logic [DEAD_BITS-1:0]       w_dcnt_next;
   logic [RESOLUTION_BITS-1:0] r_duty_active;
   logic [RESOLUTION_BITS-1:0] r_pending;
   logic                       r_pend;
   logic                       r_period_start;
   logic                       w_raw;
   logic                       w_wrap;
   logic                       w_dead_zero;
   logic [DEAD_BITS-1:0]       w_dead_load;

   // Unsigned compare; duty 0 never asserts, duty MAX_VALUE tops out one
   // cycle short of a full period.
   assign w_raw       = (i_count < r_duty_active);
   assign w_wrap      = i_ena && (i_count == MAX_VALUE);
   assign w_dead_zero = (i_dead_time == '0);
   // The down-counter ends at 0, so loading D-1 gives exactly D dead cycles.
   assign w_dead_load = i_dead_time - DEAD_BITS'(1);

   //---------------------------------------------------------------------------
   // Duty double buffer and period-start pulse
   //---------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_duty_active  <= '0;
         r_pending      <= '0;
         r_pend         <= 1'b0;
         r_period_start <= 1'b0;
      end else begin
         r_period_start <= w_wrap;
         if (w_wrap && r_pend) begin
            r_duty_active <= r_pending;
            r_pend        <= 1'b0;
         end
         // Placed after the transfer so a write on the wrap edge wins the
         // pend flag while the transfer still uses the old pending value.
         if (i_duty_wr) begin
            r_pending <= i_duty_in;
            r_pend    <= 1'b1;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Gate FSM: state register
   //---------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_OFF;
         r_dcnt  <= '0;
      end else if (i_ena) begin
         r_state <= w_state_next;
         r_dcnt  <= w_dcnt_next;
      end
   end

   //---------------------------------------------------------------------------
   // Gate FSM: next state
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_dcnt_next  = r_dcnt;
      case (r_state)
         S_OFF: begin
            w_state_next = S_LOW;
         end
         S_LOW: begin
            if (w_raw) begin
               if (w_dead_zero) begin
                  w_state_next = S_HIGH;
               end else begin
                  w_state_next = S_DT_RISE;
                  w_dcnt_next  = w_dead_load;
               end
            end
         end
         S_DT_RISE: begin
            // A pulse shorter than the dead interval never reaches the gate.
            if (!w_raw) begin
               w_state_next = S_LOW;
            end else if (r_dcnt == '0) begin
               w_state_next = S_HIGH;
            end else begin
               w_dcnt_next = r_dcnt - DEAD_BITS'(1);
            end
         end
         S_HIGH: begin
            if (!w_raw) begin
               if (w_dead_zero) begin
                  w_state_next = S_LOW;
               end else begin
                  w_state_next = S_DT_FALL;
                  w_dcnt_next  = w_dead_load;
               end
            end
         end
         S_DT_FALL: begin
            // Always runs to completion, even if raw reasserts.
            if (r_dcnt == '0) begin
               w_state_next = S_LOW;
            end else begin
               w_dcnt_next = r_dcnt - DEAD_BITS'(1);
            end
         end
         default: begin
            w_state_next = S_OFF;
         end
      endcase
   end

   // Decoded straight from the state register: reset clears both gates
   // without waiting for a clock edge, and no state drives both high.
   assign o_pwm_h        = (r_state == S_HIGH);
   assign o_pwm_l        = (r_state == S_LOW);
   assign o_duty_active  = r_duty_active;
   assign o_pend         = r_pend;
   assign o_period_start = r_period_start;

endmodule
